// File: rtl/writeback_group_arbiter_pkg.sv
// Shared ID and writeback-packet types for the writeback path between execution
// units and ID management.
package writeback_group_arbiter_pkg;

    localparam int unsigned LOG2_MAX_IDS = 3;
    localparam int unsigned WB_DATA_W    = 32;

    typedef logic [LOG2_MAX_IDS-1:0] id_t;

    typedef struct packed {
        logic                 valid;
        id_t                  id;
        logic [WB_DATA_W-1:0] data;
    } wb_packet_t;

endpackage

// File: rtl/writeback_group_arbiter_round_robin_select.sv
// Combinational one-hot selector: first set request found scanning upward from
// start, wrapping modulo WIDTH. A start of zero gives plain lowest-index priority.
module round_robin_select #(
    parameter int unsigned WIDTH = 3,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned off = 0; off < WIDTH; off++) begin
            pos     = (32'(start) + off) % WIDTH;
            pos_idx = IDX_W'(pos);
            if (!any && req[pos_idx]) begin
                grant[pos_idx] = 1'b1;
                idx            = pos_idx;
                any            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_group_arbiter.sv
// Arbitrates completions of one WB group's units onto a single registered writeback
// port. Define CVA5_WB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority.
module writeback_group_arbiter
    import writeback_group_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned DATA_W    = WB_DATA_W,
    parameter int unsigned ID_W      = LOG2_MAX_IDS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]        unit_ack,
    input  logic                        wb_ready,
    output logic                        wb_valid,
    output logic [ID_W-1:0]             wb_id,
    output logic [DATA_W-1:0]           wb_data
);

    localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    wb_packet_t             wb_q;
    wb_packet_t             wb_d;
    logic                   load_en_c;
    logic [NUM_UNITS-1:0]   grant_c;
    logic [IDX_W-1:0]       grant_idx_c;
    logic                   any_c;
    logic [IDX_W-1:0]       rr_ptr_c;
    logic [ID_W-1:0]        sel_id_c;
    logic [DATA_W-1:0]      sel_rd_c;

    // Output slot is free when empty or being drained this cycle.
    assign load_en_c = ~wb_q.valid | wb_ready;
    assign unit_ack  = grant_c & {NUM_UNITS{load_en_c & ~rst}};

`ifdef CVA5_WB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Next search starts just past the last granted unit.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_c && load_en_c) begin
            rr_ptr_d = (grant_idx_c == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    assign rr_ptr_c = rr_ptr_q;
`else
    assign rr_ptr_c = '0;
`endif

    generate
        if (NUM_UNITS == 1) begin : g_single
            assign grant_c     = unit_done;
            assign grant_idx_c = '0;
            assign any_c       = unit_done[0];
        end else begin : g_arb
            round_robin_select #(
                .WIDTH (NUM_UNITS)
            ) u_select (
                .req   (unit_done),
                .start (rr_ptr_c),
                .grant (grant_c),
                .idx   (grant_idx_c),
                .any   (any_c)
            );
        end
    endgenerate

    assign sel_id_c = unit_id[grant_idx_c * ID_W +: ID_W];
    assign sel_rd_c = unit_rd[grant_idx_c * DATA_W +: DATA_W];

    always_comb begin
        wb_d = wb_q;
        if (load_en_c) begin
            wb_d.valid = any_c;
            if (any_c) begin
                wb_d.id   = LOG2_MAX_IDS'(sel_id_c);
                wb_d.data = WB_DATA_W'(sel_rd_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wb_q <= '0;
        else     wb_q <= wb_d;
    end

    assign wb_valid = wb_q.valid;
    assign wb_id    = ID_W'(wb_q.id);
    assign wb_data  = DATA_W'(wb_q.data);

    // Protocol checks on the unit side.
    logic id_dup_c;

    always_comb begin
        id_dup_c = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            for (int j = i + 1; j < NUM_UNITS; j++) begin
                if (unit_done[i] && unit_done[j] &&
                    unit_id[i*ID_W +: ID_W] == unit_id[j*ID_W +: ID_W]) begin
                    id_dup_c = 1'b1;
                end
            end
        end
    end

    a_id_unique: assert property (@(posedge clk) disable iff (rst) !id_dup_c);

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_hold_chk
            a_done_held: assert property (@(posedge clk) disable iff (rst)
                (unit_done[gi] && !unit_ack[gi]) |=> unit_done[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_writeback_group_arbiter.sv
// Bench for writeback_group_arbiter: directed vector table plus randomized traffic
// checked against a queue-free behavioural reference of the arbitration rules.
module tb_writeback_group_arbiter;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  unit_done;
    logic [N*3-1:0]  unit_id;
    logic [N*32-1:0] unit_rd;
    logic [N-1:0]  unit_ack;
    logic          wb_ready;
    logic          wb_valid;
    logic [2:0]    wb_id;
    logic [31:0]   wb_data;

    int errors = 0;
    int checks = 0;

    writeback_group_arbiter #(.NUM_UNITS(N), .DATA_W(32), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .unit_done (unit_done),
        .unit_id   (unit_id),
        .unit_rd   (unit_rd),
        .unit_ack  (unit_ack),
        .wb_ready  (wb_ready),
        .wb_valid  (wb_valid),
        .wb_id     (wb_id),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  done;
        logic [2:0]  id0;
        logic [2:0]  id1;
        logic [2:0]  id2;
        logic        ready;
        logic [2:0]  exp_ack;
        logic        exp_valid;
        logic [2:0]  exp_id;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic logic [31:0] rdv(input int u, input logic [2:0] id);
        return {24'hC0DE00, 4'(u), 1'b0, id};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a posedge: drive, check ack mid-cycle, check outputs after edge.
    task automatic apply(input vec_t v, input string name);
        rst       = v.rst;
        unit_done = v.done;
        unit_id   = {v.id2, v.id1, v.id0};
        unit_rd   = {rdv(2, v.id2), rdv(1, v.id1), rdv(0, v.id0)};
        wb_ready  = v.ready;
        @(negedge clk);
        chk({name, ".ack"}, 32'(unit_ack), 32'(v.exp_ack));
        @(posedge clk); #1;
        chk({name, ".valid"}, 32'(wb_valid), 32'(v.exp_valid));
        chk({name, ".id"}, 32'(wb_id), 32'(v.exp_id));
        chk({name, ".data"}, wb_data, v.exp_data);
    endtask

    // Reference model state for randomized traffic.
    logic        m_valid;
    logic [2:0]  m_id;
    logic [31:0] m_data;
    int          m_ptr;
    logic [2:0]  u_pend;
    logic [2:0]  u_id [N];
    logic [31:0] u_data [N];

    initial begin
        logic [2:0]  prev_ack;
        logic [2:0]  exp_ack;
        logic        r;
        logic        rdy;
        logic        load;
        int          win;
        logic [2:0]  cand;
        logic        clash;

        vecs[0]  = '{1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, 1'b0, 3'd0, 32'h0};
        vecs[1]  = '{1'b0, 3'b010, 3'd0, 3'd5, 3'd0, 1'b1, 3'b010, 1'b1, 3'd5, 32'hC0DE0015};
        vecs[2]  = '{1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000, 1'b0, 3'd5, 32'hC0DE0015};
        vecs[3]  = '{1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000, 1'b0, 3'd0, 32'h0};
        vecs[4]  = '{1'b0, 3'b111, 3'd1, 3'd2, 3'd3, 1'b1, 3'b001, 1'b1, 3'd1, 32'hC0DE0001};
        vecs[5]  = '{1'b0, 3'b110, 3'd1, 3'd2, 3'd3, 1'b1, 3'b010, 1'b1, 3'd2, 32'hC0DE0012};
        vecs[6]  = '{1'b0, 3'b100, 3'd1, 3'd2, 3'd3, 1'b1, 3'b100, 1'b1, 3'd3, 32'hC0DE0023};
        vecs[7]  = '{1'b0, 3'b001, 3'd4, 3'd0, 3'd0, 1'b1, 3'b001, 1'b1, 3'd4, 32'hC0DE0004};
        vecs[8]  = '{1'b0, 3'b100, 3'd0, 3'd0, 3'd6, 1'b0, 3'b000, 1'b1, 3'd4, 32'hC0DE0004};
        vecs[9]  = '{1'b0, 3'b100, 3'd0, 3'd0, 3'd6, 1'b0, 3'b000, 1'b1, 3'd4, 32'hC0DE0004};
        vecs[10] = '{1'b0, 3'b100, 3'd0, 3'd0, 3'd6, 1'b0, 3'b000, 1'b1, 3'd4, 32'hC0DE0004};
        vecs[11] = '{1'b0, 3'b100, 3'd0, 3'd0, 3'd6, 1'b1, 3'b100, 1'b1, 3'd6, 32'hC0DE0026};
        vecs[12] = '{1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000, 1'b0, 3'd6, 32'hC0DE0026};
        vecs[13] = '{1'b0, 3'b001, 3'd7, 3'd0, 3'd0, 1'b1, 3'b001, 1'b1, 3'd7, 32'hC0DE0007};
        vecs[14] = '{1'b0, 3'b001, 3'd1, 3'd0, 3'd0, 1'b0, 3'b000, 1'b1, 3'd7, 32'hC0DE0007};
        vecs[15] = '{1'b1, 3'b001, 3'd1, 3'd0, 3'd0, 1'b0, 3'b000, 1'b0, 3'd0, 32'h0};
        vecs[16] = '{1'b0, 3'b001, 3'd1, 3'd0, 3'd0, 1'b0, 3'b001, 1'b1, 3'd1, 32'hC0DE0001};
        vecs[17] = '{1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000, 1'b0, 3'd1, 32'hC0DE0001};

        rst = 1'b1; unit_done = '0; unit_id = '0; unit_rd = '0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) apply(vecs[k], $sformatf("vec%0d", k));

`ifdef CVA5_WB_ROUND_ROBIN_EN
        // Unit 0 keeps requesting; unit 2 joins after unit 0's first grant and wins next.
        apply('{1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000, 1'b0, 3'd0, 32'h0}, "rr_rst");
        apply('{1'b0, 3'b001, 3'd1, 3'd0, 3'd0, 1'b1, 3'b001, 1'b1, 3'd1, 32'hC0DE0001}, "rr_a");
        apply('{1'b0, 3'b101, 3'd2, 3'd0, 3'd3, 1'b1, 3'b100, 1'b1, 3'd3, 32'hC0DE0023}, "rr_b");
        apply('{1'b0, 3'b001, 3'd2, 3'd0, 3'd0, 1'b1, 3'b001, 1'b1, 3'd2, 32'hC0DE0002}, "rr_wrap");
        apply('{1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 1'b1, 3'b000, 1'b0, 3'd2, 32'hC0DE0002}, "rr_idle");
`endif

        // Randomized traffic against the reference model.
        apply('{1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 1'b0, 3'b000, 1'b0, 3'd0, 32'h0}, "rnd_rst");
        m_valid = 1'b0; m_id = '0; m_data = '0; m_ptr = 0;
        u_pend = '0; prev_ack = '0;
        for (int i = 0; i < N; i++) begin u_id[i] = '0; u_data[i] = '0; end

        for (int c = 0; c < 3000; c++) begin
            // Units: retire acked results, optionally present a fresh one with a unique ID.
            for (int i = 0; i < N; i++) begin
                if (prev_ack[i]) u_pend[i] = 1'b0;
                if (!u_pend[i] && $urandom_range(1, 0) == 1) begin
                    cand = 3'($urandom_range(7, 0));
                    for (int t = 0; t < 8; t++) begin
                        clash = 1'b0;
                        for (int o = 0; o < N; o++)
                            if (o != i && u_pend[o] && u_id[o] == cand) clash = 1'b1;
                        if (clash) cand = cand + 3'd1;
                    end
                    u_pend[i] = 1'b1;
                    u_id[i]   = cand;
                    u_data[i] = $urandom;
                end
            end
            r   = ($urandom_range(39, 0) == 0);
            rdy = ($urandom_range(3, 0) != 0);

            rst       = r;
            wb_ready  = rdy;
            unit_done = u_pend;
            unit_id   = {u_id[2], u_id[1], u_id[0]};
            unit_rd   = {u_data[2], u_data[1], u_data[0]};

            load = !m_valid || rdy;
            win  = -1;
            for (int n = 0; n < N; n++) begin
`ifdef CVA5_WB_ROUND_ROBIN_EN
                if (win < 0 && u_pend[(m_ptr + n) % N]) win = (m_ptr + n) % N;
`else
                if (win < 0 && u_pend[n]) win = n;
`endif
            end
            exp_ack = '0;
            if (!r && load && win >= 0) exp_ack[win] = 1'b1;

            @(negedge clk);
            chk($sformatf("rnd%0d.ack", c), 32'(unit_ack), 32'(exp_ack));
            @(posedge clk); #1;

            if (r) begin
                m_valid = 1'b0; m_id = '0; m_data = '0; m_ptr = 0;
            end else if (load) begin
                m_valid = (win >= 0);
                if (win >= 0) begin
                    m_id   = u_id[win];
                    m_data = u_data[win];
                    m_ptr  = (win + 1) % N;
                end
            end
            prev_ack = exp_ack;

            chk($sformatf("rnd%0d.valid", c), 32'(wb_valid), 32'(m_valid));
            chk($sformatf("rnd%0d.id", c), 32'(wb_id), 32'(m_id));
            chk($sformatf("rnd%0d.data", c), wb_data, m_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
